rd_delay_mem_p: RTL and testbench
=================================

// Module: rd_delay_mem_p
// PURPOSE
//  Parametrised single-clock memory with independent write and read request
//  ports and a programmable read-to-data pipeline delay. Generalises the
//  fixed 1-bit delayed-read memory to configurable width, depth and collision
//  policy. Adds write acknowledge, out-of-range error flags and an optional
//  post-reset zero-fill. Sits between bus-side request logic and the
//  SVA-checked datapath.
// PARAMETERS
//  ADDR_W           4  address width
//  DATA_W           8  data width
//  DEPTH           16  words implemented, 1..2**ADDR_W; any value allowed
//  ADDR2READ_DELAY  0  extra pipeline cycles between a read and rd_served (0..15)
//  WRITE_FIRST      1  same-cycle write+read to one addr: 1=new data, 0=old data
//  INIT_ZERO        1  1=zero-fill all DEPTH words after reset; 0=no fill
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst        in   1       synchronous reset, active-high
//  write      in   1       write request; wdata and addr sampled this cycle
//  read       in   1       read request; addr sampled this cycle
//  addr       in   ADDR_W  shared address for write and read
//  wdata      in   DATA_W  write data
//  ready      out  1       high when requests are accepted (not rst, not INIT)
//  wr_valid   out  1       pulse 1 cycle after an accepted in-range write
//  wr_err     out  1       pulse 1 cycle after a write with addr>=DEPTH
//  rd_served  out  1       rdata valid this cycle
//  rdata      out  DATA_W  read data; 0 when rd_served low or rd_err high
//  rd_err     out  1       valid with rd_served when the read had addr>=DEPTH
// BEHAVIOUR
//  - Reset: ready, wr_valid, wr_err, rd_served, rd_err and rdata are 0 while
//    rst is high and in the cycle after. Read pipeline is flushed; in-flight
//    reads are dropped and never served. Array contents hold unless filled.
//  - FSM (state_t): INIT -> RUN.
//    rst forces INIT when INIT_ZERO=1, else RUN.
//    INIT writes 0 to words 0..DEPTH-1, one per cycle, via fill counter.
//    INIT -> RUN after word DEPTH-1; ready rises in the first RUN cycle.
//    INIT lasts exactly DEPTH cycles.
//  - Requests are ignored while ready=0: no array write, no pulses.
//  - Write accepted at edge N (write & ready):
//    addr<DEPTH -> array updated, wr_valid=1 for cycle N+1.
//    addr>=DEPTH -> no update, wr_err=1 for cycle N+1.
//  - Read accepted at edge N: array read at N.
//    rd_served, rdata and rd_err are valid for exactly cycle N+1+ADDR2READ_DELAY.
//    Fully pipelined: one read per cycle; back-to-back reads serve
//    back-to-back in order.
//  - Same-cycle write+read, same in-range addr: WRITE_FIRST=1 returns wdata;
//    WRITE_FIRST=0 returns the prior content. The array is written either way.
//  - Write after read to the same addr while the read is in flight does not
//    affect the served data (data captured at request).
//  - Out-of-range read: rd_served=1, rd_err=1, rdata=0.
//  - Address comparison is unsigned, ADDR_W bits. DEPTH=2**ADDR_W never errs.
// STRUCTURE
//  - Package rd_delay_mem_pkg holds:
//    typedef enum logic {INIT, RUN} state_t;
//    MAX_DELAY=15;
//    the rd_pipe_t struct {valid, err, data}.
//  - Sub-module rd_delay_pipe #(DATA_W, DELAY) carries the shift register of
//    rd_pipe_t; DELAY=0 is a pass-through.
//  - Top holds the array, FSM, fill counter, collision mux and write pulses.
// TESTING
//  1. INIT_ZERO=1, DEPTH=16: release rst -> ready=0 for 16 cycles, then 1;
//     read every addr -> rdata=0.
//  2. DELAY=3: write addr 5=0xA5 at N, read 5 at N+2 -> wr_valid at N+1;
//     rd_served with 0xA5 only at N+6.
//  3. Same-cycle write 0x3C / read addr 7 (old 0x11):
//     WRITE_FIRST=1 -> 0x3C; WRITE_FIRST=0 -> 0x11.
//  4. DEPTH=12: write addr 13 -> wr_err pulse, no wr_valid, array unchanged;
//     read addr 12 -> rd_served=1, rd_err=1, rdata=0.
//  5. DELAY=2: 4 back-to-back reads of addrs 0..3 holding 1..4 ->
//     4 consecutive rd_served cycles with 1,2,3,4.
//  6. rst asserted with 2 reads in flight -> no rd_served afterwards;
//     INIT restarts; ready low 16 cycles.

Source files
------------

// File: rtl/rd_delay_mem_pkg.sv
// Shared types for the delayed-read memory: FSM state and the read-pipeline
// record carried from the array read to rd_served.
package rd_delay_mem_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int MAX_DELAY  = 15;
  localparam int MAX_DATA_W = 32;

  // data is sized for the widest supported DATA_W; narrower users zero the top
  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [MAX_DATA_W-1:0] data;
  } rd_pipe_t;

endpackage

// File: rtl/rd_delay_mem_p_pipe.sv
// Shift register that delays a read response by DELAY cycles; DELAY=0 is a
// pass-through. Only valid/err are reset so a flush drops in-flight reads.
module rd_delay_pipe
  import rd_delay_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DELAY  = 0
) (
  input  logic     clk,
  input  logic     rst,
  input  rd_pipe_t in_s,
  output rd_pipe_t out_s
);

  localparam logic [MAX_DATA_W-1:0] DATA_MASK = MAX_DATA_W'((64'd1 << DATA_W) - 64'd1);

  rd_pipe_t in_m;

  always_comb begin
    in_m      = in_s;
    in_m.data = in_s.data & DATA_MASK;
  end

  if (DELAY == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_s = in_m;
  end else begin : g_pipe
    rd_pipe_t stage_d [DELAY];
    rd_pipe_t stage_q [DELAY];

    always_comb begin
      stage_d[0] = in_m;
      for (int i = 1; i < DELAY; i++) stage_d[i] = stage_q[i-1];
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < DELAY; i++) begin
        stage_q[i].data <= stage_d[i].data;
        if (rst) begin
          stage_q[i].valid <= 1'b0;
          stage_q[i].err   <= 1'b0;
        end else begin
          stage_q[i].valid <= stage_d[i].valid;
          stage_q[i].err   <= stage_d[i].err;
        end
      end
    end

    assign out_s = stage_q[DELAY-1];
  end

endmodule

// File: rtl/rd_delay_mem_p.sv
// Single-clock memory with write/read request ports, a programmable read
// latency, out-of-range flags and optional zero-fill after reset.
module rd_delay_mem_p
  import rd_delay_mem_pkg::*;
#(
  parameter int ADDR_W          = 4,
  parameter int DATA_W          = 8,
  parameter int DEPTH           = 16,
  parameter int ADDR2READ_DELAY = 0,
  parameter int WRITE_FIRST     = 1,
  parameter int INIT_ZERO       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              wr_valid,
  output logic              wr_err,
  output logic              rd_served,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_err
);

  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PIPE_DELAY = (ADDR2READ_DELAY > MAX_DELAY) ? MAX_DELAY : ADDR2READ_DELAY;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  fill_q, fill_d;
  logic              ready_q, ready_d;
  logic              wr_valid_q, wr_valid_d;
  logic              wr_err_q, wr_err_d;
  logic              fill_we, in_range, wr_acc, rd_acc;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  rd_pipe_t          rd_p0_d, rd_p0_q, rd_out;

  assign ready    = ready_q & ~rst;
  assign in_range = (32'(addr) < 32'(DEPTH));
  assign idx      = addr[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    fill_we = 1'b0;
    if (state_q == INIT) begin
      fill_we = 1'b1;
      fill_d  = fill_q + 1'b1;
      if (fill_q == IDX_W'(DEPTH - 1)) begin
        state_d = RUN;
        fill_d  = '0;
      end
    end
    ready_d = (state_d == RUN);

    wr_acc     = write & ready;
    rd_acc     = read & ready;
    wr_valid_d = wr_acc & in_range;
    wr_err_d   = wr_acc & ~in_range;

    // write and read share addr, so any accepted write collides with the read
    rd_word = mem_q[idx];
    if (WRITE_FIRST != 0 && wr_acc) rd_word = wdata;

    rd_p0_d       = '0;
    rd_p0_d.valid = rd_acc;
    rd_p0_d.err   = rd_acc & ~in_range;
    if (rd_acc && in_range) rd_p0_d.data[DATA_W-1:0] = rd_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= (INIT_ZERO != 0) ? INIT : RUN;
      fill_q        <= '0;
      ready_q       <= 1'b0;
      wr_valid_q    <= 1'b0;
      wr_err_q      <= 1'b0;
      rd_p0_q.valid <= 1'b0;
      rd_p0_q.err   <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      ready_q       <= ready_d;
      wr_valid_q    <= wr_valid_d;
      wr_err_q      <= wr_err_d;
      rd_p0_q.valid <= rd_p0_d.valid;
      rd_p0_q.err   <= rd_p0_d.err;
    end
    rd_p0_q.data <= rd_p0_d.data;
  end

  always_ff @(posedge clk) begin
    if (fill_we && !rst) mem_q[fill_q] <= '0;
    else if (wr_acc && in_range) mem_q[idx] <= wdata;
  end

  // p0 stage above supplies the one mandatory cycle; the pipe adds the rest
  rd_delay_pipe #(
    .DATA_W (DATA_W),
    .DELAY  (PIPE_DELAY)
  ) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .in_s  (rd_p0_q),
    .out_s (rd_out)
  );

  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_out.data;

  assign wr_valid  = wr_valid_q;
  assign wr_err    = wr_err_q;
  assign rd_served = rd_out.valid;
  assign rd_err    = rd_out.valid & rd_out.err;
  assign rdata     = (rd_out.valid && !rd_out.err) ? rd_out.data[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_rd_delay_mem_p.sv
// Scoreboard bench: two instances (DEPTH12/DELAY3/write-first and
// DEPTH16/DELAY2/read-first) driven with the same directed requests.
module tb_rd_delay_mem_p;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       write = 1'b0, read = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] wdata = 8'd0;

  logic       rdy_a, wv_a, we_a, srv_a, re_a;
  logic [7:0] rd_a;
  logic       rdy_b, wv_b, we_b, srv_b, re_b;
  logic [7:0] rd_b;

  always #5 clk = ~clk;

  rd_delay_mem_p #(.ADDR_W(4), .DATA_W(8), .DEPTH(12), .ADDR2READ_DELAY(3),
                   .WRITE_FIRST(1), .INIT_ZERO(1)) dut_a (
    .clk(clk), .rst(rst), .write(write), .read(read), .addr(addr), .wdata(wdata),
    .ready(rdy_a), .wr_valid(wv_a), .wr_err(we_a), .rd_served(srv_a),
    .rdata(rd_a), .rd_err(re_a));

  rd_delay_mem_p #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .ADDR2READ_DELAY(2),
                   .WRITE_FIRST(0), .INIT_ZERO(1)) dut_b (
    .clk(clk), .rst(rst), .write(write), .read(read), .addr(addr), .wdata(wdata),
    .ready(rdy_b), .wr_valid(wv_b), .wr_err(we_b), .rd_served(srv_b),
    .rdata(rd_b), .rd_err(re_b));

  typedef struct { int due; bit err; bit [7:0] data; } rexp_t;
  typedef struct { int due; bit v; bit e; } wexp_t;

  rexp_t rq_a[$], rq_b[$];
  wexp_t wq_a[$], wq_b[$];
  logic [7:0] m_a [16];
  logic [7:0] m_b [16];

  int cyc = 0;
  int rst_end = 1 << 30;
  bit chk_en = 1'b0;
  int n_chk = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  task automatic chk_rd(string p, bit due, rexp_t e, logic srv, logic err, logic [7:0] d);
    if (due) begin
      chk({p, "_rd_served"}, 32'(srv), 32'd1);
      chk({p, "_rd_err"}, 32'(err), 32'(e.err));
      chk({p, "_rdata"}, 32'(d), 32'(e.data));
    end else begin
      chk({p, "_rd_served_idle"}, 32'(srv), 32'd0);
      chk({p, "_rdata_idle"}, 32'(d), 32'd0);
    end
  endtask

  task automatic chk_wr(string p, bit due, wexp_t e, logic v, logic er);
    chk({p, "_wr_valid"}, 32'(v), due ? 32'(e.v) : 32'd0);
    chk({p, "_wr_err"}, 32'(er), due ? 32'(e.e) : 32'd0);
  endtask

  always @(negedge clk) begin : mon
    rexp_t r;
    wexp_t w;
    bit    due;
    if (chk_en) begin
      chk("a_ready", 32'(rdy_a), 32'(cyc >= rst_end + 12));
      chk("b_ready", 32'(rdy_b), 32'(cyc >= rst_end + 16));

      due = (rq_a.size() > 0) && (rq_a[0].due == cyc);
      if (due) r = rq_a.pop_front();
      chk_rd("a", due, r, srv_a, re_a, rd_a);
      due = (rq_b.size() > 0) && (rq_b[0].due == cyc);
      if (due) r = rq_b.pop_front();
      chk_rd("b", due, r, srv_b, re_b, rd_b);

      due = (wq_a.size() > 0) && (wq_a[0].due == cyc);
      if (due) w = wq_a.pop_front();
      chk_wr("a", due, w, wv_a, we_a);
      due = (wq_b.size() > 0) && (wq_b[0].due == cyc);
      if (due) w = wq_b.pop_front();
      chk_wr("b", due, w, wv_b, we_b);
    end
  end

  // Inputs set at cyc=c are sampled at edge c+1; responses appear at negedge
  // cyc = c+1 (write pulses) and cyc = c+1+DELAY (reads).
  task automatic req(bit w, bit r, logic [3:0] a, logic [7:0] d);
    int c;
    @(negedge clk);
    #1;
    write = w; read = r; addr = a; wdata = d;
    c = cyc;
    if (c >= rst_end + 12) begin
      if (r) rq_a.push_back('{c + 4, (a >= 12), (a >= 12) ? 8'h00 : (w ? d : m_a[a])});
      if (w) begin
        wq_a.push_back('{c + 1, (a < 12), (a >= 12)});
        if (a < 12) m_a[a] = d;
      end
    end
    if (c >= rst_end + 16) begin
      if (r) rq_b.push_back('{c + 3, 1'b0, m_b[a]});
      if (w) begin
        wq_b.push_back('{c + 1, 1'b1, 1'b0});
        m_b[a] = d;
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) req(1'b0, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    #1;
    rst = 1'b1; write = 1'b0; read = 1'b0;
    rst_end = 1 << 30;
    rq_a.delete(); rq_b.delete(); wq_a.delete(); wq_b.delete();
    repeat (n) @(negedge clk);
    #1;
    chk_en = 1'b1;
    rst = 1'b0;
    rst_end = cyc;
    for (int i = 0; i < 16; i++) begin
      m_a[i] = 8'h00;
      m_b[i] = 8'h00;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    idle(18);
    // zero-filled contents; A flags 12..15 as out of range
    for (int i = 0; i < 16; i++) req(1'b0, 1'b1, 4'(i), 8'd0);
    idle(5);
    // write then read two cycles later
    req(1'b1, 1'b0, 4'd5, 8'hA5);
    idle(1);
    req(1'b0, 1'b1, 4'd5, 8'd0);
    idle(6);
    // same-cycle write/read collision
    req(1'b1, 1'b0, 4'd7, 8'h11);
    req(1'b1, 1'b1, 4'd7, 8'h3C);
    req(1'b0, 1'b1, 4'd7, 8'd0);
    idle(5);
    // out-of-range accesses on the 12-word instance
    req(1'b1, 1'b0, 4'd13, 8'h77);
    req(1'b0, 1'b1, 4'd13, 8'd0);
    req(1'b0, 1'b1, 4'd12, 8'd0);
    req(1'b0, 1'b1, 4'd1, 8'd0);
    idle(5);
    // back-to-back reads serve back-to-back
    for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 4'(i), 8'(i + 1));
    for (int i = 0; i < 4; i++) req(1'b0, 1'b1, 4'(i), 8'd0);
    idle(6);
    // reset with reads in flight, then a write during INIT that must be ignored
    req(1'b0, 1'b1, 4'd0, 8'd0);
    req(1'b0, 1'b1, 4'd1, 8'd0);
    do_reset(2);
    req(1'b1, 1'b0, 4'd2, 8'hFF);
    idle(17);
    req(1'b0, 1'b1, 4'd2, 8'd0);
    req(1'b0, 1'b1, 4'd15, 8'd0);
    req(1'b0, 1'b1, 4'd3, 8'd0);
    idle(6);
    chk("a_rd_pending", 32'(rq_a.size()), 32'd0);
    chk("b_rd_pending", 32'(rq_b.size()), 32'd0);
    chk("a_wr_pending", 32'(wq_a.size()), 32'd0);
    chk("b_wr_pending", 32'(wq_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
